// File: rtl/loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        LOAD,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_WIDTH      = 16;
    localparam int unsigned CSUM_WIDTH     = 8;

endpackage

// File: rtl/word_assembler.sv
// Packs accepted payload bytes LSB-first into words; pulses word_valid
// for one cycle after the last byte lane of a word has been accepted.
module word_assembler
    import loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  byte_en,
    input  logic [7:0]            byte_data,
    output logic                  lane_last,
    output logic                  word_valid,
    output logic [DATA_WIDTH-1:0] word
);

    localparam int unsigned LANE_W = $clog2(BYTES_PER_WORD);

    logic [LANE_W-1:0]     lane;
    logic [DATA_WIDTH-9:0] sr;

    assign lane_last = (lane == LANE_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane       <= '0;
            sr         <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else if (clear) begin
            lane       <= '0;
            sr         <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_en && lane_last;
            if (byte_en) begin
                lane <= lane + LANE_W'(1);
                if (lane_last) begin
                    word <= {byte_data, sr};
                end else begin
                    sr <= {byte_data, sr[DATA_WIDTH-9:8]};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Receives a framed program image (length, LE words, XOR checksum), writes it
// into inst_mem and holds the CPU in reset until the image is verified.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           word_count
);

    localparam int unsigned CAPACITY = 2 ** (ADDR_WIDTH - 2);
    localparam int unsigned TW       = $clog2(TIMEOUT + 1);

    state_t                state, state_nxt;
    logic                  accept, frame_start, pay_byte;
    logic                  lane_last, last_word, timed_out;
    logic [7:0]            len_lo;
    logic [LEN_WIDTH-1:0]  length, len_full;
    logic [CSUM_WIDTH-1:0] csum;
    logic [TW-1:0]         timer;

    assign accept      = byte_valid && byte_ready;
    assign frame_start = start && (state == IDLE || state == DONE || state == ERR);
    assign pay_byte    = accept && (state == LOAD);
    assign len_full    = {byte_data, len_lo};
    assign timed_out   = !accept && (timer == TW'(TIMEOUT - 1));
    // word_count is always caught up here: the previous word's strobe lands
    // at least three cycles before the next word's final byte can arrive.
    assign last_word   = (word_count + 16'd1) == length;

    word_assembler #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (frame_start),
        .byte_en   (pay_byte),
        .byte_data (byte_data),
        .lane_last (lane_last),
        .word_valid(wr_en),
        .word      (wr_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        cpu_rst    = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LEN0;
            end
            LEN0: begin
                byte_ready = 1'b1;
                cpu_rst    = 1'b1;
                if (accept) state_nxt = LEN1;
            end
            LEN1: begin
                byte_ready = 1'b1;
                cpu_rst    = 1'b1;
                if (accept) begin
                    if (len_full == '0)                      state_nxt = CSUM;
                    else if ({16'd0, len_full} > CAPACITY)   state_nxt = ERR;
                    else                                     state_nxt = LOAD;
                end
            end
            LOAD: begin
                byte_ready = 1'b1;
                cpu_rst    = 1'b1;
                if (accept && lane_last && last_word) state_nxt = CSUM;
            end
            CSUM: begin
                byte_ready = 1'b1;
                cpu_rst    = 1'b1;
                if (accept) state_nxt = (byte_data == csum) ? DONE : ERR;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = LEN0;
            end
            ERR: begin
                err     = 1'b1;
                cpu_rst = 1'b1;
                if (start) state_nxt = LEN0;
            end
            default: state_nxt = IDLE;
        endcase
        if (byte_ready && timed_out) state_nxt = ERR;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_lo     <= '0;
            length     <= '0;
            csum       <= '0;
            timer      <= '0;
            wr_addr    <= ADDR_WIDTH'(BASE_ADDR);
            word_count <= '0;
        end else if (frame_start) begin
            csum       <= '0;
            timer      <= '0;
            wr_addr    <= ADDR_WIDTH'(BASE_ADDR);
            word_count <= '0;
        end else begin
            if (wr_en) begin
                word_count <= word_count + 16'd1;
                wr_addr    <= wr_addr + ADDR_WIDTH'(BYTES_PER_WORD);
            end
            if (accept && state == LEN0) len_lo <= byte_data;
            if (accept && state == LEN1) length <= len_full;
            if (pay_byte) csum <= csum ^ byte_data;
            if (!byte_ready || accept || timed_out) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames
// checked against a frame-level model of expected writes and final status.
module tb_imem_loader;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 12;
    localparam int unsigned BASE = 0;
    localparam int unsigned TMO  = 100;
    localparam int unsigned CAP  = 1 << (AW - 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready, wr_en, cpu_rst, done, err;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [15:0]   word_count;

    int vectors = 0;
    int miscompares = 0;

    logic [AW+DW-1:0] wq[$];
    logic [AW+DW-1:0] ew[$];
    logic [7:0]       pay[$];
    bit               exp_done, exp_err;
    int               exp_wc;

    imem_loader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE),
        .TIMEOUT   (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_en === 1'b1) wq.push_back({wr_addr, wr_data});

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    function automatic logic [7:0] pay_xor();
        logic [7:0] x = 8'h00;
        foreach (pay[i]) x ^= pay[i];
        return x;
    endfunction

    // Frame-level reference: expected writes and final status from length, payload and checksum.
    task automatic model(input int len, input logic [7:0] cs);
        ew.delete();
        if (len > int'(CAP)) begin
            exp_err = 1'b1; exp_done = 1'b0; exp_wc = 0;
        end else begin
            for (int i = 0; i < len; i++)
                ew.push_back({AW'(BASE + 4 * i), pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]});
            exp_wc   = len;
            exp_done = (pay_xor() == cs);
            exp_err  = !exp_done;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int stalls);
        stalls = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && stalls < 20) begin
            @(negedge clk);
            stalls++;
        end
        if (byte_ready !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL byte_ready_wait: byte_ready=%b, required 1", byte_ready);
            byte_valid = 1'b0;
            return;
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [7:0] cs, input int gapmax, output int stalls);
        int s;
        stalls = 0;
        pulse_start();
        send_byte(8'(len), s);      stalls += s;
        send_byte(8'(len >> 8), s); stalls += s;
        if (len <= int'(CAP)) begin
            foreach (pay[i]) begin
                repeat ($urandom_range(0, gapmax)) @(negedge clk);
                send_byte(pay[i], s); stalls += s;
            end
            send_byte(cs, s); stalls += s;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic load_example_payload();
        pay = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h15, 8'h00};
    endtask

    task automatic test_reset();
        logic [AW+DW+20:0] got;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        got = {byte_ready, wr_en, wr_addr, wr_data, cpu_rst, done, err, word_count};
        vectors++;
        if (got !== {2'b00, AW'(BASE), DW'(0), 3'b000, 16'd0}) begin
            miscompares++; $display("FAIL reset_values: got %h, required %h", got, {2'b00, AW'(BASE), DW'(0), 19'd0});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({byte_ready, cpu_rst, done, err} !== 4'b0000) begin
            miscompares++; $display("FAIL idle_after_reset: got %b, required 0000", {byte_ready, cpu_rst, done, err});
        end
    endtask

    task automatic test_valid_frame();
        int s;
        load_example_payload();
        wq.delete();
        // 0x35 is the XOR of the eight payload bytes
        send_frame(2, 8'h35, 1, s);
        vectors++;
        if (wq.size() != 2) begin
            miscompares++; $display("FAIL valid_write_count: got %0d, required 2", wq.size());
        end else begin
            vectors++;
            if (wq[0] !== {AW'(BASE), 32'h00A00513} || wq[1] !== {AW'(BASE + 4), 32'h00150593}) begin
                miscompares++; $display("FAIL valid_writes: got %h %h, required %h %h", wq[0], wq[1],
                                        {AW'(BASE), 32'h00A00513}, {AW'(BASE + 4), 32'h00150593});
            end
        end
        vectors++;
        if ({done, err, cpu_rst} !== 3'b100 || word_count !== 16'd2) begin
            miscompares++; $display("FAIL valid_status: done/err/cpu_rst=%b wc=%0d, required 100 wc=2", {done, err, cpu_rst}, word_count);
        end
    endtask

    task automatic test_bad_checksum();
        int s;
        load_example_payload();
        wq.delete();
        send_frame(2, 8'h8B, 0, s);
        vectors++;
        if (wq.size() != 2 || wq[0] !== {AW'(BASE), 32'h00A00513} || wq[1] !== {AW'(BASE + 4), 32'h00150593}) begin
            miscompares++; $display("FAIL badcs_writes: got %0d writes, required the 2 example words", wq.size());
        end
        vectors++;
        if ({done, err, cpu_rst} !== 3'b011 || word_count !== 16'd2) begin
            miscompares++; $display("FAIL badcs_status: done/err/cpu_rst=%b wc=%0d, required 011 wc=2", {done, err, cpu_rst}, word_count);
        end
    endtask

    task automatic test_zero_length();
        int s;
        pay.delete();
        wq.delete();
        send_frame(0, 8'h00, 0, s);
        vectors++;
        if (wq.size() != 0 || {done, err, cpu_rst} !== 3'b100 || word_count !== 16'd0) begin
            miscompares++; $display("FAIL zero_length: writes=%0d done/err/cpu_rst=%b wc=%0d, required 0 100 0",
                                    wq.size(), {done, err, cpu_rst}, word_count);
        end
    endtask

    task automatic test_overflow();
        int s;
        int lens[2];
        lens[0] = 16'hFFFF;
        lens[1] = CAP + 1;
        foreach (lens[k]) begin
            wq.delete();
            pulse_start();
            send_byte(8'(lens[k]), s);
            send_byte(8'(lens[k] >> 8), s);
            vectors++;
            if ({err, done, cpu_rst, byte_ready} !== 4'b1010) begin
                miscompares++; $display("FAIL overflow_%0d: err/done/cpu_rst/ready=%b, required 1010", lens[k], {err, done, cpu_rst, byte_ready});
            end
            repeat (3) @(negedge clk);
            vectors++;
            if (wq.size() != 0 || word_count !== 16'd0 || err !== 1'b1) begin
                miscompares++; $display("FAIL overflow_nowrite_%0d: writes=%0d wc=%0d err=%b, required 0 0 1", lens[k], wq.size(), word_count, err);
            end
        end
    endtask

    task automatic test_back_to_back_capacity();
        int s, bad;
        pay.delete();
        for (int i = 0; i < int'(4 * CAP); i++) pay.push_back(8'($urandom));
        model(CAP, pay_xor());
        wq.delete();
        send_frame(CAP, pay_xor(), 0, s);
        vectors++;
        if (s != 0) begin
            miscompares++; $display("FAIL b2b_stalls: got %0d stall cycles, required 0", s);
        end
        bad = 0;
        if (wq.size() == ew.size()) foreach (ew[i]) if (wq[i] !== ew[i]) bad++;
        vectors++;
        if (wq.size() != ew.size() || bad != 0) begin
            miscompares++; $display("FAIL b2b_writes: got %0d writes (%0d wrong), required %0d", wq.size(), bad, ew.size());
        end
        vectors++;
        if ({done, err} !== 2'b10 || word_count !== 16'(CAP)) begin
            miscompares++; $display("FAIL b2b_status: done/err=%b wc=%0d, required 10 wc=%0d", {done, err}, word_count, CAP);
        end
    endtask

    task automatic test_timeout();
        int s, n;
        wq.delete();
        pulse_start();
        send_byte(8'h02, s);
        send_byte(8'h00, s);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), s);
        repeat (TMO - 2) @(negedge clk);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++; $display("FAIL timeout_early: err=%b before %0d idle cycles, required 0", err, TMO);
        end
        n = 0;
        while (err !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if ({err, done, cpu_rst} !== 3'b101 || word_count !== 16'd0 || wq.size() != 0) begin
            miscompares++; $display("FAIL timeout: err/done/cpu_rst=%b wc=%0d writes=%0d, required 101 0 0",
                                    {err, done, cpu_rst}, word_count, wq.size());
        end
    endtask

    task automatic test_reset_mid_load();
        int s;
        logic [AW+DW+20:0] got;
        pay.delete();
        for (int i = 0; i < 12; i++) pay.push_back(8'($urandom));
        wq.delete();
        pulse_start();
        send_byte(8'h03, s);
        send_byte(8'h00, s);
        for (int i = 0; i < 6; i++) send_byte(pay[i], s);
        repeat (2) @(negedge clk);
        vectors++;
        if (wq.size() != 1) begin
            miscompares++; $display("FAIL midload_first_word: got %0d writes, required 1", wq.size());
        end
        rst = 1'b0;
        #1;
        got = {byte_ready, wr_en, wr_addr, wr_data, cpu_rst, done, err, word_count};
        vectors++;
        if (got !== {2'b00, AW'(BASE), DW'(0), 3'b000, 16'd0}) begin
            miscompares++; $display("FAIL midload_reset_values: got %h, required %h", got, {2'b00, AW'(BASE), DW'(0), 19'd0});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        load_example_payload();
        model(2, 8'h35);
        wq.delete();
        send_frame(2, 8'h35, 1, s);
        vectors++;
        if (wq.size() != 2 || wq[0] !== ew[0] || wq[1] !== ew[1] || done !== 1'b1 || word_count !== 16'd2) begin
            miscompares++; $display("FAIL midload_reload: writes=%0d done=%b wc=%0d, required 2 writes from base, done=1 wc=2",
                                    wq.size(), done, word_count);
        end
    endtask

    task automatic test_random_frames();
        int s, len, bad;
        logic [7:0] cs;
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(0, 6);
            pay.delete();
            for (int i = 0; i < 4 * len; i++) pay.push_back(8'($urandom));
            cs = pay_xor();
            if ($urandom_range(0, 2) == 0) cs ^= 8'(1 << $urandom_range(0, 7));
            model(len, cs);
            wq.delete();
            send_frame(len, cs, 2, s);
            bad = 0;
            if (wq.size() == ew.size()) foreach (ew[i]) if (wq[i] !== ew[i]) bad++;
            vectors++;
            if (wq.size() != ew.size() || bad != 0) begin
                miscompares++; $display("FAIL rand%0d_writes: got %0d writes (%0d wrong), required %0d", f, wq.size(), bad, ew.size());
            end
            vectors++;
            if ({done, err, cpu_rst} !== {exp_done, exp_err, exp_err} || word_count !== 16'(exp_wc)) begin
                miscompares++; $display("FAIL rand%0d_status: done/err/cpu_rst=%b wc=%0d, required %b wc=%0d",
                                        f, {done, err, cpu_rst}, word_count, {exp_done, exp_err, exp_err}, exp_wc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_zero_length();
        test_overflow();
        test_back_to_back_capacity();
        test_timeout();
        test_reset_mid_load();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
